// File: rtl/calc_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and the
// sign/mantissa/exponent number format exchanged with the divider.
package calc_pkg;

  localparam int MANT_W = 34;
  localparam int EXP_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                     sign;
    logic [MANT_W-1:0]        mant;
    logic signed [EXP_W-1:0]  exp;
  } fp_num_t;

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request bit at or above i_rr,
// wrapping past NREQ-1 back to 0.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_rr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_vld
);

  logic [IDXW:0]   w_pos  [NREQ];
  logic [IDXW-1:0] w_wrap [NREQ];
  logic [NREQ-1:0] w_cand;

  // w_cand[k] is the request at distance k from the pointer
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
    assign w_pos[gi]  = {1'b0, i_rr} + (IDXW+1)'(gi);
    assign w_wrap[gi] = (w_pos[gi] >= (IDXW+1)'(NREQ)) ?
                        IDXW'(w_pos[gi] - (IDXW+1)'(NREQ)) : IDXW'(w_pos[gi]);
    assign w_cand[gi] = i_req[w_wrap[gi]];
  end

  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_cand[k]) begin
        o_idx = w_wrap[k];
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one divider between NREQ requesters. The divider's
// reset comes from ~resetN at the level above (ORed with divAbort when
// DIV_ARB_TIMEOUT_EN is defined, which also enables the wait watchdog).
module div_arbiter
  import calc_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int IDXW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          reqSignN,
  input  logic [MANT_W*NREQ-1:0]   reqMantN,
  input  logic [EXP_W*NREQ-1:0]    reqExpN,
  input  logic [NREQ-1:0]          reqSignD,
  input  logic [MANT_W*NREQ-1:0]   reqMantD,
  input  logic [EXP_W*NREQ-1:0]    reqExpD,
  output logic [NREQ-1:0]          ack,
  output logic                     rspSign,
  output logic [MANT_W-1:0]        rspMant,
  output logic signed [EXP_W-1:0]  rspExp,
  output logic                     rspErr,
  output logic                     busy,
  output logic                     divEval,
  output logic                     divSignA,
  output logic [MANT_W-1:0]        divMantA,
  output logic signed [EXP_W-1:0]  divExpA,
  output logic                     divSignB,
  output logic [MANT_W-1:0]        divMantB,
  output logic signed [EXP_W-1:0]  divExpB,
  input  logic                     divDone,
  input  logic                     divSign,
  input  logic [MANT_W-1:0]        divMant,
  input  logic signed [EXP_W-1:0]  divExp
`ifdef DIV_ARB_TIMEOUT_EN
  ,
  output logic                     divAbort
`endif
);

  arb_state_t      r_state;
  logic [IDXW-1:0] r_rr;
  logic [IDXW-1:0] r_g;
  logic [IDXW-1:0] w_gnt_idx;
  logic            w_gnt_vld;
  fp_num_t         w_num;
  fp_num_t         w_den;
`ifdef DIV_ARB_TIMEOUT_EN
  logic [7:0]      r_wait_cnt;
`endif

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .i_req (req),
    .i_rr  (r_rr),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_vld)
  );

  assign w_num = '{sign: reqSignN[w_gnt_idx],
                   mant: reqMantN[w_gnt_idx*MANT_W +: MANT_W],
                   exp:  reqExpN[w_gnt_idx*EXP_W +: EXP_W]};
  assign w_den = '{sign: reqSignD[w_gnt_idx],
                   mant: reqMantD[w_gnt_idx*MANT_W +: MANT_W],
                   exp:  reqExpD[w_gnt_idx*EXP_W +: EXP_W]};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_g      <= '0;
      ack      <= '0;
      rspSign  <= 1'b0;
      rspMant  <= '0;
      rspExp   <= '0;
      rspErr   <= 1'b0;
      busy     <= 1'b0;
      divEval  <= 1'b0;
      divSignA <= 1'b0;
      divMantA <= '0;
      divExpA  <= '0;
      divSignB <= 1'b0;
      divMantB <= '0;
      divExpB  <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
      divAbort   <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef DIV_ARB_TIMEOUT_EN
      divAbort <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_g      <= w_gnt_idx;
            busy     <= 1'b1;
            divSignA <= w_den.sign;
            divMantA <= w_den.mant;
            divExpA  <= w_den.exp;
            divSignB <= w_num.sign;
            divMantB <= w_num.mant;
            divExpB  <= w_num.exp;
            // Zero divisor never reaches the divider
            if (w_den.mant == '0) begin
              rspSign <= w_num.sign ^ w_den.sign;
              rspMant <= '0;
              rspExp  <= '0;
              rspErr  <= 1'b1;
              r_state <= S_RESP;
            end else begin
              divEval <= 1'b1;
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          divEval <= 1'b0;
          r_state <= S_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (divDone) begin
            rspSign <= divSign;
            rspMant <= divMant;
            rspExp  <= divExp;
            rspErr  <= 1'b0;
            r_state <= S_RESP;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else if (r_wait_cnt == 8'(TIMEOUT_CYC - 1)) begin
            rspMant  <= '0;
            rspExp   <= '0;
            rspErr   <= 1'b1;
            divAbort <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          ack[r_g] <= 1'b1;
          r_rr     <= (r_g == IDXW'(NREQ - 1)) ? '0 : r_g + 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed, table-driven bench for div_arbiter with a fixed-latency divider
// model. The timeout sequence only runs when DIV_ARB_TIMEOUT_EN is defined.
module tb_div_arbiter;

  localparam int NREQ = 2;

  logic                clock;
  logic                resetN;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     reqSignN, reqSignD;
  logic [34*NREQ-1:0]  reqMantN, reqMantD;
  logic [7*NREQ-1:0]   reqExpN, reqExpD;
  logic [NREQ-1:0]     ack;
  logic                rspSign, rspErr, busy, divEval;
  logic [33:0]         rspMant;
  logic signed [6:0]   rspExp;
  logic                divSignA, divSignB;
  logic [33:0]         divMantA, divMantB;
  logic signed [6:0]   divExpA, divExpB;
  logic                divDone, divSign;
  logic [33:0]         divMant;
  logic signed [6:0]   divExp;
`ifdef DIV_ARB_TIMEOUT_EN
  logic                divAbort;
`endif

  div_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(64)) dut (
    .clock(clock), .resetN(resetN), .req(req),
    .reqSignN(reqSignN), .reqMantN(reqMantN), .reqExpN(reqExpN),
    .reqSignD(reqSignD), .reqMantD(reqMantD), .reqExpD(reqExpD),
    .ack(ack), .rspSign(rspSign), .rspMant(rspMant), .rspExp(rspExp),
    .rspErr(rspErr), .busy(busy), .divEval(divEval),
    .divSignA(divSignA), .divMantA(divMantA), .divExpA(divExpA),
    .divSignB(divSignB), .divMantB(divMantB), .divExpB(divExpB),
    .divDone(divDone), .divSign(divSign), .divMant(divMant), .divExp(divExp)
`ifdef DIV_ARB_TIMEOUT_EN
    , .divAbort(divAbort)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int                idx;
    logic              sn;  logic [33:0] mn;  logic signed [6:0] en;
    logic              sd;  logic [33:0] md;  logic signed [6:0] ed;
    logic              rs;  logic [33:0] rm;  logic signed [6:0] re;  // divider model answer
    int                evals;
    logic              e_sign; logic [33:0] e_mant; logic signed [6:0] e_exp; logic e_err;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eval_cnt = 0;
  int div_cnt = -1;
  int done_cyc = -1;
  logic model_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // One clock: sample just after the edge, then advance the divider model.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (divEval) eval_cnt++;
    if (model_en) begin
      divDone = 1'b0;
      if (divEval) div_cnt = 3;
      else if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0) begin
          divDone  = 1'b1;
          done_cyc = cyc;
          div_cnt  = -1;
        end
      end
    end
  endtask

  task automatic load_ops(input vec_t v);
    reqSignN[v.idx]          = v.sn;
    reqMantN[v.idx*34 +: 34] = v.mn;
    reqExpN[v.idx*7 +: 7]    = v.en;
    reqSignD[v.idx]          = v.sd;
    reqMantD[v.idx*34 +: 34] = v.md;
    reqExpD[v.idx*7 +: 7]    = v.ed;
    divSign = v.rs;
    divMant = v.rm;
    divExp  = v.re;
  endtask

  task automatic run_txn(input int id, input vec_t v);
    int start, ack_c, e0;
    logic got;
    logic [NREQ-1:0] a;
    logic s, er, b;
    logic [33:0] m;
    logic signed [6:0] e;
    got = 1'b0; ack_c = 0; a = '0; s = 0; er = 0; b = 0; m = '0; e = '0;
    load_ops(v);
    req = '0;
    req[v.idx] = 1'b1;
    start = cyc;
    e0 = eval_cnt;
    done_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ack != '0) begin
        got = 1'b1; ack_c = cyc; a = ack; s = rspSign; m = rspMant;
        e = rspExp; er = rspErr; b = busy;
        req = '0;
        break;
      end
    end
    $display("txn %0d: req%0d ack=%b sign=%b mant=%0d exp=%0d err=%b evals=%0d",
             id, v.idx, a, s, m, e, er, eval_cnt - e0);
    check("ack_seen", 64'(got), 64'd1);
    if (got) begin
      check("ack_owner", 64'(a), 64'(1 << v.idx));
      check("rsp_sign", 64'(s), 64'(v.e_sign));
      check("rsp_mant", 64'(m), 64'(v.e_mant));
      check("rsp_exp", 64'(e), 64'(v.e_exp));
      check("rsp_err", 64'(er), 64'(v.e_err));
      check("busy_at_ack", 64'(b), 64'd0);
      check("eval_pulses", 64'(eval_cnt - e0), 64'(v.evals));
      check("opA_mant", 64'(divMantA), 64'(v.md));
      check("opB_mant", 64'(divMantB), 64'(v.mn));
      if (v.evals == 0) check("zero_div_latency", 64'(ack_c - start), 64'd2);
      else              check("done_to_ack", 64'(ack_c - done_cyc), 64'd2);
      tick();
      check("ack_one_cycle", 64'(ack), 64'd0);
      check("rsp_hold", 64'(rspMant), 64'(v.e_mant));
    end
  endtask

  initial begin
    int order[4];
    int n_ack, viol, e0, bad;
    logic got;

    vecs[0] = '{0, 1'b0, 34'd6, 7'sd0, 1'b0, 34'd3, 7'sd0, 1'b0, 34'd2000000000, -7'sd9,
                1, 1'b0, 34'd2000000000, -7'sd9, 1'b0};
    vecs[1] = '{1, 1'b0, 34'd5, 7'sd0, 1'b1, 34'd0, 7'sd3, 1'b0, 34'd123, 7'sd1,
                0, 1'b1, 34'd0, 7'sd0, 1'b1};
    vecs[2] = '{1, 1'b1, 34'd10, 7'sd0, 1'b0, 34'd4, 7'sd0, 1'b1, 34'd2500000000, -7'sd9,
                1, 1'b1, 34'd2500000000, -7'sd9, 1'b0};
    vecs[3] = '{0, 1'b1, 34'd7, 7'sd0, 1'b1, 34'd0, 7'sd0, 1'b0, 34'd55, 7'sd2,
                0, 1'b0, 34'd0, 7'sd0, 1'b1};
    vecs[4] = '{0, 1'b0, 34'd1, 7'sd0, 1'b0, 34'd3, 7'sd0, 1'b0, 34'd3333333333, -7'sd10,
                1, 1'b0, 34'd3333333333, -7'sd10, 1'b0};

    resetN = 1'b0; req = '0;
    reqSignN = '0; reqMantN = '0; reqExpN = '0;
    reqSignD = '0; reqMantD = '0; reqExpD = '0;
    divDone = 1'b0; divSign = 1'b0; divMant = '0; divExp = '0;

    // Reset state
    tick(); tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_eval", 64'(divEval), 64'd0);
    check("rst_rsp", 64'({rspSign, rspErr, rspMant, rspExp}), 64'd0);
    check("rst_ops", 64'({divMantA, divMantB}), 64'd0);
    @(negedge clock); resetN = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // Reset pulled low while waiting for the divider
    load_ops(vecs[0]);
    req = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (divEval) begin got = 1'b1; break; end
    end
    check("mid_rst_eval_seen", 64'(got), 64'd1);
    tick(); tick();
    check("mid_rst_busy_before", 64'(busy), 64'd1);
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_ack", 64'(ack), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    req = '0; div_cnt = -1;
    @(negedge clock); resetN = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack != '0 || busy) bad++;
    end
    check("mid_rst_no_ack", 64'(bad), 64'd0);
    run_txn(5, vecs[0]);

    // Round robin with both requests held, starting from rr=0
    @(negedge clock); resetN = 1'b0;
    @(negedge clock); resetN = 1'b1;
    load_ops(vecs[2]);
    load_ops(vecs[0]);
    req = 2'b11;
    n_ack = 0; viol = 0; e0 = eval_cnt;
    for (int k = 0; k < 300; k++) begin
      tick();
      if ((busy == 1'b0) != (ack != '0)) viol++;
      if (ack != '0) begin
        order[n_ack] = int'(ack);
        n_ack++;
        $display("rr ack %0d: ack=%b", n_ack, ack);
        if (n_ack == 4) begin req = '0; break; end
      end
    end
    check("rr_ack_count", 64'(n_ack), 64'd4);
    if (n_ack == 4) begin
      check("rr_order0", 64'(order[0]), 64'd1);
      check("rr_order1", 64'(order[1]), 64'd2);
      check("rr_order2", 64'(order[2]), 64'd1);
      check("rr_order3", 64'(order[3]), 64'd2);
    end
    check("rr_busy_profile", 64'(viol), 64'd0);
    check("rr_evals", 64'(eval_cnt - e0), 64'd4);
    tick(); tick();
    check("rr_idle_busy", 64'(busy), 64'd0);

    // Spurious divDone while idle
    model_en = 1'b0;
    divDone = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ack != '0 || busy || divEval) bad++;
    end
    divDone = 1'b0;
    model_en = 1'b1;
    $display("spurious divDone: %0d bad cycles", bad);
    check("spurious_done", 64'(bad), 64'd0);
    run_txn(6, vecs[4]);

`ifdef DIV_ARB_TIMEOUT_EN
    begin
      int eval_c, ack_c, aborts;
      model_en = 1'b0; divDone = 1'b0;
      load_ops(vecs[0]);
      req = 2'b01;
      eval_c = -1; ack_c = -1; aborts = 0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (divEval) eval_c = cyc;
        if (divAbort) aborts++;
        if (ack != '0) begin
          ack_c = cyc;
          req = '0;
          check("to_err", 64'(rspErr), 64'd1);
          check("to_mant", 64'(rspMant), 64'd0);
          check("to_ack", 64'(ack), 64'd1);
          break;
        end
      end
      tick();
      if (divAbort) aborts++;
      $display("timeout: eval@%0d ack@%0d aborts=%0d", eval_c, ack_c, aborts);
      check("to_latency", 64'(ack_c - eval_c), 64'd66);
      check("to_abort_pulses", 64'(aborts), 64'd1);
      model_en = 1'b1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
